uart_ram_loader: RTL and testbench



---
 rtl/uart_ram_loader_if.sv | 11 +
 rtl/uart_ram_loader.sv | 211 +++++++++++++++++++++
 tb/tb_uart_ram_loader.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_ram_loader_if.sv
// RAM write port driven by the loader: strobe, word address, data and the
// ownership flag that steers the top-level write-select mux.
interface uart_ram_loader_if;
   logic        wren;
   logic [15:0] ADDR;
   logic [15:0] data;
   logic        busy;

   modport master (output wren, ADDR, data, busy);
   modport slave  (input  wren, ADDR, data, busy);
endinterface

// File: rtl/uart_ram_loader.sv
// UART-fed LC-3 program loader: A5 / LEN_hi / LEN_lo / 2N data bytes / XOR checksum.
// Each completed word produces a one-cycle write strobe the cycle after its low byte.
module uart_ram_loader #(
   parameter int CLK_HZ = 50000000,
   parameter int BAUD   = 115200,
   parameter int ADDR_W = 10
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic              RX,
   uart_ram_loader_if.master ram,
   output logic              done,
   output logic              err,
   output logic [15:0]       word_count
);
   localparam int              DIV   = CLK_HZ / BAUD;
   localparam int              CW    = $clog2(DIV);
   localparam logic [CW-1:0]   HALF  = CW'(DIV / 2 - 1);
   localparam logic [CW-1:0]   FULL  = CW'(DIV - 1);
   localparam logic [16:0]     MAX_N = 17'(2 ** ADDR_W);
   localparam logic [7:0]      SYNC  = 8'hA5;

   typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAIT} rx_state_t;
   typedef enum logic [2:0] {S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHK} state_t;

   rx_state_t     rx_state_q, rx_state_d;
   logic          rx_meta_q, rx_s_q, rx_prev_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    sh_q, sh_d;
   logic          byte_vld, frame_err;

   state_t        state_q, state_d;
   logic [7:0]    len_hi_q, len_hi_d, hi_q, hi_d, chk_q, chk_d;
   logic [15:0]   len_q, len_d, wc_q, wc_d, addr_q, addr_d, data_q, data_d;
   logic          wren_q, wren_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic          go_err;
   logic [15:0]   len_n;

   assign len_n = {len_hi_q, sh_q};

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         rx_meta_q  <= 1'b1;
         rx_s_q     <= 1'b1;
         rx_prev_q  <= 1'b1;
         rx_state_q <= R_IDLE;
         cnt_q      <= '0;
         bit_q      <= '0;
         sh_q       <= '0;
      end else begin
         rx_meta_q  <= RX;
         rx_s_q     <= rx_meta_q;
         rx_prev_q  <= rx_s_q;
         rx_state_q <= rx_state_d;
         cnt_q      <= cnt_d;
         bit_q      <= bit_d;
         sh_q       <= sh_d;
      end
   end

   // Samples land mid-bit: half a bit after the start edge, then every full bit.
   always_comb begin
      rx_state_d = rx_state_q;
      cnt_d      = cnt_q;
      bit_d      = bit_q;
      sh_d       = sh_q;
      byte_vld   = 1'b0;
      frame_err  = 1'b0;
      unique case (rx_state_q)
         R_IDLE: if (rx_prev_q && !rx_s_q) begin
            rx_state_d = R_START;
            cnt_d      = HALF;
         end
         R_START: begin
            if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
            else if (rx_s_q) rx_state_d = R_IDLE;
            else begin
               rx_state_d = R_DATA;
               cnt_d      = FULL;
               bit_d      = '0;
            end
         end
         R_DATA: begin
            if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
            else begin
               sh_d  = {rx_s_q, sh_q[7:1]};
               cnt_d = FULL;
               bit_d = bit_q + 1'b1;
               if (bit_q == 3'd7) rx_state_d = R_STOP;
            end
         end
         R_STOP: begin
            if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
            else if (rx_s_q) begin
               byte_vld   = 1'b1;
               rx_state_d = R_IDLE;
            end else begin
               frame_err  = 1'b1;
               rx_state_d = R_WAIT;
            end
         end
         R_WAIT:  if (rx_s_q) rx_state_d = R_IDLE;
         default: rx_state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q  <= S_IDLE;
         len_hi_q <= '0;
         hi_q     <= '0;
         chk_q    <= '0;
         len_q    <= '0;
         wc_q     <= '0;
         addr_q   <= '0;
         data_q   <= '0;
         wren_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         len_hi_q <= len_hi_d;
         hi_q     <= hi_d;
         chk_q    <= chk_d;
         len_q    <= len_d;
         wc_q     <= wc_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         wren_q   <= wren_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      len_hi_d = len_hi_q;
      hi_d     = hi_q;
      chk_d    = chk_q;
      len_d    = len_q;
      wc_d     = wc_q;
      addr_d   = addr_q;
      data_d   = data_q;
      wren_d   = 1'b0;
      busy_d   = busy_q;
      done_d   = done_q;
      err_d    = err_q;
      go_err   = 1'b0;
      if (frame_err && state_q != S_IDLE) go_err = 1'b1;
      else if (byte_vld) begin
         unique case (state_q)
            S_IDLE: if (sh_q == SYNC) begin
               state_d = S_LEN_HI;
               busy_d  = 1'b1;
               done_d  = 1'b0;
               err_d   = 1'b0;
               wc_d    = '0;
               chk_d   = '0;
            end
            S_LEN_HI: begin
               len_hi_d = sh_q;
               state_d  = S_LEN_LO;
            end
            S_LEN_LO: begin
               len_d = len_n;
               if (len_n == '0) state_d = S_CHK;
               else if ({1'b0, len_n} > MAX_N) go_err = 1'b1;
               else state_d = S_DATA_HI;
            end
            S_DATA_HI: begin
               hi_d    = sh_q;
               chk_d   = chk_q ^ sh_q;
               state_d = S_DATA_LO;
            end
            S_DATA_LO: begin
               wren_d  = 1'b1;
               data_d  = {hi_q, sh_q};
               addr_d  = 16'(wc_q[ADDR_W-1:0]);
               chk_d   = chk_q ^ sh_q;
               wc_d    = wc_q + 16'd1;
               state_d = (wc_q + 16'd1 == len_q) ? S_CHK : S_DATA_HI;
            end
            S_CHK: begin
               if (sh_q == chk_q) begin
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  state_d = S_IDLE;
               end else go_err = 1'b1;
            end
            default: state_d = S_IDLE;
         endcase
      end
      // Abort keeps whatever was already written; only status and ownership change.
      if (go_err) begin
         err_d   = 1'b1;
         busy_d  = 1'b0;
         state_d = S_IDLE;
      end
   end

   assign ram.wren   = wren_q;
   assign ram.ADDR   = addr_q;
   assign ram.data   = data_q;
   assign ram.busy   = busy_q;
   assign done       = done_q;
   assign err        = err_q;
   assign word_count = wc_q;
endmodule

// File: tb/tb_uart_ram_loader.sv
// Directed and randomized frames over a bit-banged UART line, checked against a frame-level model.
module tb_uart_ram_loader;
   localparam int DIV = 16;

   logic        clk, rst_n, rx, done, err;
   logic [15:0] wc;
   int          tests, fails, dbl;
   logic        wren_prev;
   logic [7:0]  frame[$];
   logic [31:0] obs_wr[$];
   logic [31:0] exp_wr[$];
   logic        exp_done, exp_err;
   logic [15:0] exp_wc;

   uart_ram_loader_if ram ();

   uart_ram_loader #(.CLK_HZ(160), .BAUD(10), .ADDR_W(4)) dut (
      .Clk(clk), .Reset_n(rst_n), .RX(rx), .ram(ram),
      .done(done), .err(err), .word_count(wc)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(negedge clk) begin
      if (ram.wren === 1'b1) begin
         obs_wr.push_back({ram.ADDR, ram.data});
         if (wren_prev === 1'b1) dbl++;
      end
      wren_prev = ram.wren;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      rx = 1'b0;
      repeat (DIV) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (DIV) @(negedge clk);
      end
      rx = stop;
      repeat (DIV) @(negedge clk);
      rx = 1'b1;
      repeat (DIV) @(negedge clk);
   endtask

   // Frame-level reference: what a well-formed byte stream should leave in RAM and status.
   task automatic model();
      int         n;
      logic [7:0] x;
      exp_wr.delete();
      exp_done = 1'b0;
      exp_err  = 1'b0;
      exp_wc   = 16'd0;
      n = {frame[1], frame[2]};
      if (n > 16) exp_err = 1'b1;
      else begin
         x = 8'h00;
         for (int i = 0; i < n; i++) begin
            exp_wr.push_back({16'(i), frame[3 + 2*i], frame[4 + 2*i]});
            x = x ^ frame[3 + 2*i] ^ frame[4 + 2*i];
         end
         exp_wc = 16'(n);
         if (frame[3 + 2*n] == x) exp_done = 1'b1;
         else exp_err = 1'b1;
      end
   endtask

   task automatic run_frame(input string tag);
      obs_wr.delete();
      foreach (frame[i]) send_byte(frame[i], 1'b1);
      repeat (4) @(negedge clk);
      model();
      check({tag, " writes"}, obs_wr.size(), exp_wr.size());
      for (int i = 0; i < exp_wr.size() && i < obs_wr.size(); i++)
         check({tag, " addr/data"}, obs_wr[i], exp_wr[i]);
      check({tag, " done"}, done, exp_done);
      check({tag, " err"}, err, exp_err);
      check({tag, " busy"}, ram.busy, 1'b0);
      check({tag, " word_count"}, wc, exp_wc);
   endtask

   task automatic check_zero(input string tag);
      check({tag, " wren"}, ram.wren, 1'b0);
      check({tag, " ADDR"}, ram.ADDR, 16'h0);
      check({tag, " data"}, ram.data, 16'h0);
      check({tag, " busy"}, ram.busy, 1'b0);
      check({tag, " done"}, done, 1'b0);
      check({tag, " err"}, err, 1'b0);
      check({tag, " word_count"}, wc, 16'h0);
   endtask

   initial begin
      int         n;
      logic [7:0] x, b;
      tests = 0; fails = 0; dbl = 0; wren_prev = 1'b0;
      rx = 1'b1;
      rst_n = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      repeat (200) @(negedge clk);
      check_zero("reset idle");

      frame = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
      run_frame("good frame");

      frame = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
      run_frame("bad checksum");

      frame = '{8'hA5, 8'h00, 8'h11};
      run_frame("length 17");

      frame = '{8'hA5, 8'h00, 8'h00, 8'h00};
      run_frame("length 0");

      frame = '{8'hA5, 8'h00, 8'h10};
      x = 8'h00;
      for (int i = 0; i < 32; i++) begin
         b = 8'(i * 7 + 3);
         frame.push_back(b);
         x ^= b;
      end
      frame.push_back(x);
      run_frame("length 16");

      obs_wr.delete();
      send_byte(8'hA5, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h02, 1'b1);
      send_byte(8'h12, 1'b1);
      send_byte(8'h34, 1'b0);
      repeat (4) @(negedge clk);
      check("stop error err", err, 1'b1);
      check("stop error done", done, 1'b0);
      check("stop error busy", ram.busy, 1'b0);
      check("stop error writes", obs_wr.size(), 0);
      frame = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
      run_frame("after stop error");

      // A start-bit glitch shortly before a real frame must not swallow its sync byte.
      rx = 1'b0;
      repeat (3) @(negedge clk);
      rx = 1'b1;
      repeat (20) @(negedge clk);
      frame = '{8'hA5, 8'h00, 8'h01, 8'hBE, 8'hEF, 8'h51};
      run_frame("after glitch");

      obs_wr.delete();
      send_byte(8'hA5, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h02, 1'b1);
      send_byte(8'h12, 1'b1);
      send_byte(8'h34, 1'b1);
      send_byte(8'hAB, 1'b1);
      rx = 1'b0;
      repeat (40) @(negedge clk);
      check("mid frame busy", ram.busy, 1'b1);
      check("mid frame word_count", wc, 16'd1);
      check("mid frame data", ram.data, 16'h1234);
      rst_n = 1'b0;
      rx = 1'b1;
      #1;
      check_zero("async reset");
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      frame = '{8'hA5, 8'h00, 8'h02, 8'h0F, 8'hF0, 8'h55, 8'hAA, 8'hFF};
      run_frame("after reset");

      for (int k = 0; k < 4; k++) begin
         n = $urandom_range(0, 20);
         frame.delete();
         frame.push_back(8'hA5);
         frame.push_back(8'h00);
         frame.push_back(8'(n));
         if (n <= 16) begin
            x = 8'h00;
            for (int i = 0; i < 2 * n; i++) begin
               b = 8'($urandom_range(0, 255));
               frame.push_back(b);
               x ^= b;
            end
            if ($urandom_range(0, 1) == 0) x ^= 8'($urandom_range(1, 255));
            frame.push_back(x);
         end
         run_frame("random frame");
      end

      check("no back-to-back wren", dbl, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
